// File: rtl/deck_ram_arbiter.sv
// deck_ram_arbiter: shares the 64x4 deck RAM between init, shuffle, deal.
// Build option: DECK_ARB_ROUND_ROBIN_EN selects round-robin IDLE arbitration.
module deck_ram_arbiter #(
   parameter int DECK_SIZE = 52,
   parameter int MAX_HOLD  = 255,
   parameter int HOLD_W    = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  req,
   output logic [2:0]  gnt,
   input  logic [2:0]  acc,
   input  logic [2:0]  we,
   input  logic [17:0] addr_in,
   input  logic [11:0] wdata_in,
   input  logic [3:0]  ram_q,
   output logic [5:0]  ram_addr,
   output logic [3:0]  ram_wdata,
   output logic        ram_wren,
   output logic        ram_clken,
   output logic [3:0]  rd_data,
   output logic [2:0]  rd_valid,
   output logic        addr_err,
   output logic        hold_tmo
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state;
   logic [1:0]        owner;
   logic [HOLD_W-1:0] hold_cnt;
   logic [1:0]        win;
   logic              tmo_hit;
   logic [5:0]        sel_addr;
   logic [3:0]        sel_wdata;
   logic              sel_we;
   logic              acc_ok;
   logic              in_rng;
   logic              rd_pend;
   logic [1:0]        rd_tag;

`ifdef DECK_ARB_ROUND_ROBIN_EN
   logic [1:0] rr_ptr;
   logic [1:0] s0, s1, s2;

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Round-robin pick: search starts after the last granted port.
   always_comb begin
      s0 = nxt(rr_ptr);
      s1 = nxt(s0);
      s2 = nxt(s1);
      if (req[s0])      win = s0;
      else if (req[s1]) win = s1;
      else              win = s2;
   end
`else
   // Fixed-priority pick: port 0 beats 1 beats 2.
   always_comb begin
      if (req[0])      win = 2'd0;
      else if (req[1]) win = 2'd1;
      else             win = 2'd2;
   end
`endif

   assign tmo_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

   // Mux the owner's access fields and qualify the strobe.
   always_comb begin
      unique case (owner)
         2'd1: begin
            sel_addr  = addr_in[11:6];
            sel_wdata = wdata_in[7:4];
            sel_we    = we[1];
         end
         2'd2: begin
            sel_addr  = addr_in[17:12];
            sel_wdata = wdata_in[11:8];
            sel_we    = we[2];
         end
         default: begin
            sel_addr  = addr_in[5:0];
            sel_wdata = wdata_in[3:0];
            sel_we    = we[0];
         end
      endcase
      acc_ok = (state == GRANT) && gnt[owner]
               && req[owner] && acc[owner];
      in_rng = int'(sel_addr) < DECK_SIZE;
   end

   // Grant FSM: IDLE -> GRANT -> GAP -> IDLE, registered grant.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         gnt      <= '0;
         owner    <= '0;
         hold_cnt <= '0;
         hold_tmo <= 1'b0;
`ifdef DECK_ARB_ROUND_ROBIN_EN
         rr_ptr   <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (|req) begin
                  state    <= GRANT;
                  gnt      <= 3'b001 << win;
                  owner    <= win;
                  hold_cnt <= '0;
`ifdef DECK_ARB_ROUND_ROBIN_EN
                  rr_ptr   <= win;
`endif
               end
            end
            GRANT: begin
               hold_cnt <= hold_cnt + 1'b1;
               if (!req[owner] || tmo_hit) begin
                  state <= GAP;
                  gnt   <= '0;
                  if (req[owner]) hold_tmo <= 1'b1;
               end
            end
            GAP: state <= IDLE;
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

   // RAM strobe registers and read-tag pipeline back to the owner.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_wren  <= 1'b0;
         ram_clken <= 1'b0;
         addr_err  <= 1'b0;
         rd_pend   <= 1'b0;
         rd_tag    <= '0;
         rd_valid  <= '0;
      end else begin
         ram_clken <= acc_ok && in_rng;
         ram_wren  <= acc_ok && in_rng && sel_we;
         if (acc_ok && in_rng) begin
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
         end
         if (acc_ok && !in_rng) addr_err <= 1'b1;
         rd_pend  <= acc_ok && in_rng && !sel_we;
         rd_tag   <= owner;
         rd_valid <= rd_pend ? (3'b001 << rd_tag) : 3'b000;
      end
   end

   // RAM output is only meaningful while a read result is presented.
   assign rd_data = (|rd_valid) ? ram_q : 4'h0;

endmodule

// File: tb/tb_deck_ram_arbiter.sv
// tb_deck_ram_arbiter: directed bench for deck_ram_arbiter.
// Expected arbitration follows DECK_ARB_ROUND_ROBIN_EN when defined.
module tb_deck_ram_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [2:0]  req, gnt, acc, we, rd_valid;
   logic [17:0] addr_in;
   logic [11:0] wdata_in;
   logic [3:0]  ram_q, ram_wdata, rd_data;
   logic [5:0]  ram_addr;
   logic        ram_wren, ram_clken, addr_err, hold_tmo;
   logic [3:0]  mem [64];

   int nchecks = 0;
   int nerrors = 0;

   deck_ram_arbiter #(.DECK_SIZE(52), .MAX_HOLD(4), .HOLD_W(8)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .gnt(gnt),
      .acc(acc), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
      .ram_q(ram_q), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wren(ram_wren), .ram_clken(ram_clken), .rd_data(rd_data),
      .rd_valid(rd_valid), .addr_err(addr_err), .hold_tmo(hold_tmo)
   );

   always #5 clock = ~clock;

   // Synchronous single-port RAM model.
   always @(posedge clock) begin
      if (ram_clken) begin
         if (ram_wren) mem[ram_addr] <= ram_wdata;
         else          ram_q <= mem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic access(input int p, input logic w,
                         input logic [5:0] a, input logic [3:0] d);
      acc = 3'b001 << p;
      we  = w ? (3'b001 << p) : 3'b000;
      addr_in  = '0;
      wdata_in = '0;
      addr_in[6*p +: 6]  = a;
      wdata_in[4*p +: 4] = d;
   endtask

   initial begin
      ram_q = 4'h0;
      reset_n = 1'b0;
      req = '0; acc = '0; we = '0; addr_in = '0; wdata_in = '0;
      #3;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_clken", 32'(ram_clken), 0);
      check("rst_addr", 32'(ram_addr), 0);
      check("rst_rdv", 32'(rd_valid), 0);
      check("rst_err", 32'(addr_err), 0);
      check("rst_tmo", 32'(hold_tmo), 0);
      tick();
      reset_n = 1'b1;

      // Single port write then read
      req = 3'b010;
      tick();
      check("p1_gnt", 32'(gnt), 32'h2);
      access(1, 1'b1, 6'd5, 4'hA);
      tick();
      check("wr_clken", 32'(ram_clken), 1);
      check("wr_wren", 32'(ram_wren), 1);
      check("wr_addr", 32'(ram_addr), 5);
      check("wr_data", 32'(ram_wdata), 32'hA);
      access(1, 1'b0, 6'd5, 4'h0);
      tick();
      check("rd_clken", 32'(ram_clken), 1);
      check("rd_wren", 32'(ram_wren), 0);
      check("rd_early", 32'(rd_valid), 0);
      req = '0; acc = '0;
      tick();
      check("rd_valid", 32'(rd_valid), 32'h2);
      check("rd_data", 32'(rd_data), 32'hA);
      check("gap_gnt", 32'(gnt), 0);
      check("no_tmo", 32'(hold_tmo), 0);
      tick();

      // Contention: fixed start, release gap
      req = 3'b111;
      tick();
      check("cont_gnt0", 32'(gnt), 32'h1);
      req = 3'b110;
      tick();
      check("cont_gap", 32'(gnt), 0);
      tick();
      check("cont_idle", 32'(gnt), 0);
      tick();
      check("cont_gnt1", 32'(gnt), 32'h2);
      req = 3'b101;
      tick(); tick(); tick();
`ifdef DECK_ARB_ROUND_ROBIN_EN
      check("arb_after1", 32'(gnt), 32'h4);
`else
      check("arb_after1", 32'(gnt), 32'h1);
`endif
      req = '0;
      tick(); tick();
      req = 3'b100;
      tick();
      check("p2_gnt", 32'(gnt), 32'h4);
      req = 3'b011;
      tick(); tick(); tick();
      check("arb_after2", 32'(gnt), 32'h1);
      req = '0;
      tick(); tick();

      // Bounds
      req = 3'b001;
      tick();
      check("b_gnt", 32'(gnt), 32'h1);
      access(0, 1'b0, 6'd52, 4'h0);
      tick();
      check("b52_clken", 32'(ram_clken), 0);
      check("b52_err", 32'(addr_err), 1);
      access(0, 1'b1, 6'd63, 4'h7);
      tick();
      check("b63_clken", 32'(ram_clken), 0);
      check("b52_rdv", 32'(rd_valid), 0);
      req = '0; acc = '0;
      tick();
      check("b_rdv_gap", 32'(rd_valid), 0);
      tick();
      req = 3'b001;
      tick();
      access(0, 1'b1, 6'd51, 4'h3);
      tick();
      check("b51_wr", 32'(ram_clken), 1);
      check("b51_addr", 32'(ram_addr), 51);
      access(0, 1'b0, 6'd51, 4'h0);
      tick();
      check("b51_rd", 32'(ram_clken & ~ram_wren), 1);
      req = '0; acc = '0;
      tick();
      check("b51_rdv", 32'(rd_valid), 32'h1);
      check("b51_data", 32'(rd_data), 32'h3);
      check("b_err_sticky", 32'(addr_err), 1);
      tick();

      // Timeout after 4 grant cycles
      req = 3'b100;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("tmo_gnt%0d", i), 32'(gnt), 32'h4);
      end
      check("tmo_pre", 32'(hold_tmo), 0);
      tick();
      check("tmo_gnt_off", 32'(gnt), 0);
      check("tmo_flag", 32'(hold_tmo), 1);
      access(2, 1'b0, 6'd10, 4'h0);
      req = '0;
      tick();
      check("tmo_acc_ign", 32'(ram_clken), 0);
      acc = '0;
      tick();

      // Reset mid-read
      req = 3'b001;
      tick();
      access(0, 1'b0, 6'd51, 4'h0);
      tick();
      check("mr_clken", 32'(ram_clken), 1);
      reset_n = 1'b0;
      #1;
      check("mr_gnt", 32'(gnt), 0);
      check("mr_clken0", 32'(ram_clken), 0);
      check("mr_addr", 32'(ram_addr), 0);
      check("mr_err", 32'(addr_err), 0);
      check("mr_tmo", 32'(hold_tmo), 0);
      check("mr_rdd", 32'(rd_data), 0);
      req = '0; acc = '0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("mr_rdv%0d", i), 32'(rd_valid), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/deck_ram_arbiter.md
Name: deck_ram_arbiter

Overview:
- Shares the single-port 64x4 deck RAM (52 cards, addresses 0..51) between three requesters: deck initializer (port 0), shuffler (port 1), card dealer (port 2).
- Grants one requester at a time with a req/gnt lock handshake and drives the registered RAM address, data, write-enable and clock-enable.
- Returns read data to the owner with a valid pulse.
- Sits between the game FSM's datapath units and the RAM macro.

Parameters:
- DECK_SIZE, 52, valid addresses are 0..DECK_SIZE-1.
- MAX_HOLD, 255, maximum cycles one grant may be held; 0 disables the timeout.
- HOLD_W, 8, width of the hold counter; must satisfy MAX_HOLD < 2^HOLD_W.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  3  request per port; held high for the whole transaction burst.
- gnt  out  3  one-hot grant; all zero when no owner.
- acc  in  3  per-port access strobe, one access per cycle.
- we  in  3  per-port write qualifier for acc.
- addr_in  in  18  per-port address; port k uses bits [6k+5:6k].
- wdata_in  in  12  per-port write data; port k uses bits [4k+3:4k].
- ram_q  in  4  RAM read data, valid one cycle after ram_clken with ram_wren=0.
- ram_addr  out  6  registered RAM address.
- ram_wdata  out  4  registered RAM write data.
- ram_wren  out  1  registered RAM write enable.
- ram_clken  out  1  registered RAM access strobe.
- rd_data  out  4  read data, broadcast to all ports.
- rd_valid  out  3  one-hot read-data-valid for the port that issued the read.
- addr_err  out  1  sticky flag: an access with address >= DECK_SIZE was dropped.
- hold_tmo  out  1  sticky flag: a grant was revoked by the MAX_HOLD timeout.

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE; gnt=0, ram_addr=0, ram_wdata=0, ram_wren=0, ram_clken=0.
  - rd_data=0, rd_valid=0, addr_err=0, hold_tmo=0, hold counter=0, round-robin pointer=0.
- States:
  - IDLE: if any req is high, choose a winner, set gnt one-hot next cycle, go to GRANT. Fixed priority is 0 > 1 > 2.
  - GRANT: pass the owner's accesses. Go to GAP when req[owner] falls, or when the hold counter reaches MAX_HOLD-1 with MAX_HOLD != 0 (set hold_tmo).
  - GAP: exactly one cycle with gnt=0 and no RAM access, then IDLE. A new grant is therefore earliest 2 cycles after release.
- Access path:
  - An access counts only when acc[k]=1, gnt[k]=1 and req[k]=1. acc on any other port, or in IDLE or GAP, is ignored.
  - Accepted access in cycle N: ram_addr, ram_wdata, ram_wren=we[k] and ram_clken=1 are registered at N+1, for one cycle.
  - Read at N: rd_data=ram_q and rd_valid[k]=1 at N+2, for one cycle. The read-tag pipeline carries the port index independently of gnt, so a read accepted in the owner's last cycle still returns during GAP.
  - Address >= DECK_SIZE: no RAM strobe, no rd_valid, and addr_err is set. addr_err clears only on reset.
- Hold counter:
  - Clears on grant and increments each GRANT cycle.
  - On timeout the owner must drop req; gnt is withdrawn regardless.
- Simultaneous events:
  - req rising on several ports in IDLE is resolved by the arbitration rule.
  - req[owner] falling in the same cycle as acc: that access is not accepted.
- Reset mid-burst aborts immediately, with no pending rd_valid delivered.

Optional Feature:
- Macro: DECK_ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE arbitration is round-robin: search starts at the port after the last granted one, with wrap 2->0.
  - The pointer updates on each grant.
- Undefined: fixed priority 0 > 1 > 2; pointer logic absent.

Test Plan:
- Single port: port 1 req, write addr 5 data 0xA, then read addr 5 -> gnt=3'b010 one cycle after req; ram_wren=1 and ram_addr=5 one cycle after acc; rd_valid=3'b010 and rd_data=0xA two cycles after the read acc.
- Contention: req=3'b111 in IDLE -> gnt=3'b001. Port 0 drops req -> one GAP cycle with gnt=0, then gnt=3'b010.
- Round-robin, macro defined: last grant to port 2, req=3'b011 -> gnt=3'b001. Without the macro, port 2 release with req=3'b111 -> gnt=3'b001.
- Bounds: read addr 52 and write addr 63 -> no ram_clken, no rd_valid, addr_err=1 stays high until reset_n=0. Addr 51 is accessed normally.
- Timeout: MAX_HOLD=4, port 2 holds req -> gnt withdrawn after 4 GRANT cycles, hold_tmo=1, acc ignored afterwards.
- Reset mid-read: reset_n low one cycle after an accepted read -> all outputs 0 asynchronously, and no rd_valid after reset release.
